ula_arbiter: RTL and testbench

ULA_ARBITER -- requirements
Module: ula_arbiter

---
 rtl/ula_pkg.sv | 15 +
 rtl/ula.sv | 32 +++
 rtl/ula_arbiter.sv | 115 +++++++++++
 tb/tb_ula_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: shared definitions for the ULA and its two-port arbiter.
//   ULA_WIDTH  default operand/result width in bits
//   ula_op_e   2-bit ALU operation encoding (ULA_ADD, ULA_SUB, ULA_AND, ULA_OR)
package ula_pkg;

  localparam int ULA_WIDTH = 32;

  typedef enum logic [1:0] {
    ULA_ADD = 2'b00,
    ULA_SUB = 2'b01,
    ULA_AND = 2'b10,
    ULA_OR  = 2'b11
  } ula_op_e;

endpackage

// File: rtl/ula.sv
// ula: purely combinational ALU shared by the arbiter.
// Ports:
//   a, b    operands (WIDTH bits)
//   ctrl    operation select, encoded as ula_op_e
//   result  operation result, ADD/SUB wrap modulo 2^WIDTH
//   zero    high when result is all zeros
module ula
  import ula_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  always_comb begin
    result = '0;
    case (ula_op_e'(ctrl))
      ULA_ADD: result = a + b;
      ULA_SUB: result = a - b;
      ULA_AND: result = a & b;
      ULA_OR:  result = a | b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ula_arbiter.sv
// ula_arbiter: two requesters share one ula instance; at most one operation is
// accepted per cycle and its result is held in that requester's response slot.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqN_valid/ready/a/b/ctrl     request channel for requester N (N = 0, 1)
//   rspN_valid/ready/result/zero  response slot for requester N
// Build option:
//   ULA_ARB_RR_EN  defined   -> round-robin on conflict (last_grant pointer)
//                  undefined -> fixed priority, port 0 wins every conflict
module ula_arbiter
  import ula_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_ctrl,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero
);

  logic             elig0, elig1;
  logic             grant0, grant1;
  logic             port0_wins;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [1:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  // A port may be accepted if its slot is free or is being emptied this cycle,
  // so a consumer that keeps rspN_ready high sees one result per cycle.
  assign elig0 = req0_valid & (~rsp0_valid | rsp0_ready);
  assign elig1 = req1_valid & (~rsp1_valid | rsp1_ready);

`ifdef ULA_ARB_RR_EN
  logic last_grant;

  // Port 0 wins a conflict whenever port 1 was the most recent acceptance;
  // the reset value of 1 hands the first conflict to port 0.
  assign port0_wins = last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (grant0 | grant1) begin
      last_grant <= grant1;
    end
  end
`else
  assign port0_wins = 1'b1;
`endif

  // rst_n gates the grants so ready is low throughout reset.
  assign grant0 = rst_n & elig0 & (~elig1 | port0_wins);
  assign grant1 = rst_n & elig1 & ~grant0;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign alu_a    = grant1 ? req1_a    : req0_a;
  assign alu_b    = grant1 ? req1_b    : req0_b;
  assign alu_ctrl = grant1 ? req1_ctrl : req0_ctrl;

  ula #(.WIDTH(WIDTH)) u_ula (
    .a      (alu_a),
    .b      (alu_b),
    .ctrl   (alu_ctrl),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // A slot reloads on its own grant (valid stays high even if drained in the
  // same cycle); otherwise it only empties on rspN_ready and the data holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
    end else begin
      if (grant0) begin
        rsp0_valid  <= 1'b1;
        rsp0_result <= alu_result;
        rsp0_zero   <= alu_zero;
      end else if (rsp0_ready) begin
        rsp0_valid  <= 1'b0;
      end
      if (grant1) begin
        rsp1_valid  <= 1'b1;
        rsp1_result <= alu_result;
        rsp1_zero   <= alu_zero;
      end else if (rsp1_ready) begin
        rsp1_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ula_arbiter.sv
// tb_ula_arbiter: directed self-checking bench for ula_arbiter.
// Expectations follow the round-robin policy when ULA_ARB_RR_EN is defined,
// fixed port-0 priority otherwise.
module tb_ula_arbiter;

  localparam int W = 32;

  logic         clk, rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   req0_ctrl, req1_ctrl;
  logic         rsp0_valid, rsp0_ready, rsp0_zero;
  logic         rsp1_valid, rsp1_ready, rsp1_zero;
  logic [W-1:0] rsp0_result, rsp1_result;

  int nvec = 0;
  int nerr = 0;

  ula_arbiter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_ctrl   (req0_ctrl),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_ctrl   (req1_ctrl),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp0_zero   (rsp0_zero),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .rsp1_zero   (rsp1_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset;
    rst_n = 1'b0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_ctrl = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_ctrl = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    #1;
    nvec++; if (rsp0_valid !== 1'b0) begin nerr++; $display("[TB] FAIL reset_rsp0_valid got %b want 0", rsp0_valid); end
    nvec++; if (rsp1_valid !== 1'b0) begin nerr++; $display("[TB] FAIL reset_rsp1_valid got %b want 0", rsp1_valid); end
    nvec++; if (rsp0_result !== '0) begin nerr++; $display("[TB] FAIL reset_rsp0_result got %h want 0", rsp0_result); end
    nvec++; if (rsp1_result !== '0) begin nerr++; $display("[TB] FAIL reset_rsp1_result got %h want 0", rsp1_result); end
    nvec++; if ({rsp0_zero, rsp1_zero} !== 2'b00) begin nerr++; $display("[TB] FAIL reset_zero got %b want 00", {rsp0_zero, rsp1_zero}); end
    req0_valid = 1; req1_valid = 1;
    #1;
    nvec++; if ({req0_ready, req1_ready} !== 2'b00) begin nerr++; $display("[TB] FAIL reset_ready got %b want 00", {req0_ready, req1_ready}); end
    req0_valid = 0; req1_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_port0_add;
    @(negedge clk);
    req0_valid = 1; req0_a = 5; req0_b = 3; req0_ctrl = 2'b00; rsp0_ready = 1;
    #1;
    nvec++; if ({req0_ready, req1_ready} !== 2'b10) begin nerr++; $display("[TB] FAIL p0_add_ready got %b want 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    req0_valid = 0;
    nvec++; if (rsp0_valid !== 1'b1) begin nerr++; $display("[TB] FAIL p0_add_valid got %b want 1", rsp0_valid); end
    nvec++; if (rsp0_result !== 32'd8) begin nerr++; $display("[TB] FAIL p0_add_result got %h want 8", rsp0_result); end
    nvec++; if (rsp0_zero !== 1'b0) begin nerr++; $display("[TB] FAIL p0_add_zero got %b want 0", rsp0_zero); end
    @(posedge clk); #1;
    nvec++; if (rsp0_valid !== 1'b0) begin nerr++; $display("[TB] FAIL p0_drain_valid got %b want 0", rsp0_valid); end
  endtask

  task automatic test_port1_zero;
    @(negedge clk);
    req1_valid = 1; req1_a = 32'h1234; req1_b = 32'h1234; req1_ctrl = 2'b01; rsp1_ready = 1;
    @(posedge clk); #1;
    nvec++; if (rsp1_result !== 32'h0) begin nerr++; $display("[TB] FAIL p1_sub_result got %h want 0", rsp1_result); end
    nvec++; if ({rsp1_valid, rsp1_zero} !== 2'b11) begin nerr++; $display("[TB] FAIL p1_sub_flags got %b want 11", {rsp1_valid, rsp1_zero}); end
    @(negedge clk);
    req1_a = 32'hFFFF_FFFF; req1_b = 32'h1; req1_ctrl = 2'b00;
    #1;
    nvec++; if (req1_ready !== 1'b1) begin nerr++; $display("[TB] FAIL p1_drain_ready got %b want 1", req1_ready); end
    @(posedge clk); #1;
    nvec++; if ({rsp1_valid, rsp1_zero, rsp1_result} !== {2'b11, 32'h0}) begin nerr++; $display("[TB] FAIL p1_add_wrap got %b%b/%h want 11/0", rsp1_valid, rsp1_zero, rsp1_result); end
    @(negedge clk);
    req1_a = 32'hF0; req1_b = 32'h3C; req1_ctrl = 2'b10;
    @(posedge clk); #1;
    nvec++; if ({rsp1_zero, rsp1_result} !== {1'b0, 32'h30}) begin nerr++; $display("[TB] FAIL p1_and got %b/%h want 0/30", rsp1_zero, rsp1_result); end
    @(negedge clk);
    req1_valid = 0;
    @(posedge clk); #1;
    nvec++; if (rsp1_valid !== 1'b0) begin nerr++; $display("[TB] FAIL p1_drain_valid got %b want 0", rsp1_valid); end
  endtask

  task automatic test_conflict;
    logic g;
    @(negedge clk);
    req0_valid = 1; req0_a = 32'hF0; req0_b = 32'h3C; req0_ctrl = 2'b10;
    req1_valid = 1; req1_a = 32'h0F; req1_b = 32'h30; req1_ctrl = 2'b11;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef ULA_ARB_RR_EN
      g = i[0];
`else
      g = 1'b0;
`endif
      #1;
      nvec++; if ({req0_ready, req1_ready} !== {~g, g}) begin nerr++; $display("[TB] FAIL conflict_ready[%0d] got %b want %b", i, {req0_ready, req1_ready}, {~g, g}); end
      @(posedge clk); #1;
      if (!g) begin
        nvec++; if ({rsp0_valid, rsp1_valid, rsp0_result} !== {2'b10, 32'h30}) begin nerr++; $display("[TB] FAIL conflict_rsp0[%0d] got %b%b/%h want 10/30", i, rsp0_valid, rsp1_valid, rsp0_result); end
      end else begin
        nvec++; if ({rsp0_valid, rsp1_valid, rsp1_result} !== {2'b01, 32'h3F}) begin nerr++; $display("[TB] FAIL conflict_rsp1[%0d] got %b%b/%h want 01/3f", i, rsp0_valid, rsp1_valid, rsp1_result); end
      end
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    req0_valid = 1; req0_a = 1; req0_b = 1; req0_ctrl = 2'b00;
    req1_valid = 0; rsp0_ready = 0; rsp1_ready = 1;
    #1;
    nvec++; if (req0_ready !== 1'b1) begin nerr++; $display("[TB] FAIL bp_first_ready got %b want 1", req0_ready); end
    @(posedge clk); #1;
    nvec++; if ({rsp0_valid, rsp0_result} !== {1'b1, 32'd2}) begin nerr++; $display("[TB] FAIL bp_first_rsp got %b/%h want 1/2", rsp0_valid, rsp0_result); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req0_a = 10; req0_b = 1; req0_ctrl = 2'b01;
      req1_valid = 1; req1_a = 32'hFF; req1_b = 32'h0F; req1_ctrl = 2'b10;
      #1;
      nvec++; if ({req0_ready, req1_ready} !== 2'b01) begin nerr++; $display("[TB] FAIL bp_ready[%0d] got %b want 01", i, {req0_ready, req1_ready}); end
      @(posedge clk); #1;
      nvec++; if ({rsp0_valid, rsp0_zero, rsp0_result} !== {2'b10, 32'd2}) begin nerr++; $display("[TB] FAIL bp_hold[%0d] got %b%b/%h want 10/2", i, rsp0_valid, rsp0_zero, rsp0_result); end
      nvec++; if ({rsp1_valid, rsp1_result} !== {1'b1, 32'h0F}) begin nerr++; $display("[TB] FAIL bp_rsp1[%0d] got %b/%h want 1/f", i, rsp1_valid, rsp1_result); end
    end
    @(negedge clk);
    req1_valid = 0; rsp0_ready = 1;
    #1;
    nvec++; if (req0_ready !== 1'b1) begin nerr++; $display("[TB] FAIL bp_release_ready got %b want 1", req0_ready); end
    @(posedge clk); #1;
    nvec++; if ({rsp0_valid, rsp0_result} !== {1'b1, 32'd9}) begin nerr++; $display("[TB] FAIL bp_reload got %b/%h want 1/9", rsp0_valid, rsp0_result); end
    @(negedge clk);
    req0_valid = 0;
    @(posedge clk); #1;
    nvec++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin nerr++; $display("[TB] FAIL bp_drain got %b want 00", {rsp0_valid, rsp1_valid}); end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    req1_valid = 1; req1_a = 7; req1_b = 0; req1_ctrl = 2'b00; rsp1_ready = 0;
    @(posedge clk); #1;
    nvec++; if ({rsp1_valid, rsp1_result} !== {1'b1, 32'd7}) begin nerr++; $display("[TB] FAIL ar_setup got %b/%h want 1/7", rsp1_valid, rsp1_result); end
    @(negedge clk);
    req1_valid = 0;
    req0_valid = 1; req0_a = 3; req0_b = 4; req0_ctrl = 2'b00; rsp0_ready = 0;
    #2;
    rst_n = 1'b0;
    #1;
    nvec++; if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 4'b0000) begin nerr++; $display("[TB] FAIL ar_flags got %b want 0000", {rsp0_valid, rsp1_valid, req0_ready, req1_ready}); end
    nvec++; if ({rsp1_result, rsp1_zero} !== {32'h0, 1'b0}) begin nerr++; $display("[TB] FAIL ar_rsp1 got %h/%b want 0/0", rsp1_result, rsp1_zero); end
    @(posedge clk); #1;
    nvec++; if (rsp0_valid !== 1'b0) begin nerr++; $display("[TB] FAIL ar_discard got %b want 0", rsp0_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    req0_a = 32'hF0; req0_b = 32'h3C; req0_ctrl = 2'b10;
    req1_valid = 1; req1_a = 32'h0F; req1_b = 32'h30; req1_ctrl = 2'b11;
    rsp0_ready = 1; rsp1_ready = 1;
    #1;
    nvec++; if ({req0_ready, req1_ready} !== 2'b10) begin nerr++; $display("[TB] FAIL ar_first_conflict got %b want 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    nvec++; if ({rsp0_valid, rsp1_valid, rsp0_result} !== {2'b10, 32'h30}) begin nerr++; $display("[TB] FAIL ar_first_rsp got %b%b/%h want 10/30", rsp0_valid, rsp1_valid, rsp0_result); end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_port0_add();
    test_port1_zero();
    test_conflict();
    test_backpressure();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
